// File: rtl/cos_req_arbiter_pkg.sv
// Shared definitions for the cosine request arbiter slice.
// Carries the datapath-wide header macros alongside typed package constants:
//   `TOTAL_WIDTH  S3.4 sample width (8)
//   `COS_LATENCY  cosine unit pipeline latency in clock edges (5)
//   `COS_ONE      1.0 in S3.4 (16)
`ifndef TOTAL_WIDTH
`define TOTAL_WIDTH 8
`endif
`ifndef COS_LATENCY
`define COS_LATENCY 5
`endif
`ifndef COS_ONE
`define COS_ONE 16
`endif

package cos_req_arbiter_pkg;
  localparam int TOTAL_W = `TOTAL_WIDTH;
  localparam int COS_LAT = `COS_LATENCY;
endpackage

// File: rtl/cos_tag_pipe.sv
// Tag delay line tracking the owner of each in-flight cosine sample.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   clr                 synchronous clear of every stage valid (flush)
//   in_valid, in_id     tag entering stage 0
//   out_valid, out_id   last stage, aligned with the cosine unit output
//   any_valid           at least one stage holds a live sample
module cos_tag_pipe #(
  parameter int DEPTH = 6,
  parameter int ID_W  = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            clr,
  input  logic            in_valid,
  input  logic [ID_W-1:0] in_id,
  output logic            out_valid,
  output logic [ID_W-1:0] out_id,
  output logic            any_valid
);

  logic [DEPTH-1:0]           vld;
  logic [DEPTH-1:0][ID_W-1:0] ids;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld <= '0;
      ids <= '0;
    end else begin
      vld <= clr ? '0 : {vld[DEPTH-2:0], in_valid};
      ids <= {ids[DEPTH-2:0], in_id};
    end
  end

  assign out_valid = vld[DEPTH-1];
  assign out_id    = ids[DEPTH-1];
  assign any_valid = |vld;

endmodule

// File: rtl/cos_req_arbiter.sv
// Round-robin arbiter sharing one pipelined cosine unit among NUM_REQ
// requesters. At most one angle is accepted per cycle; results come back on
// a shared response bus tagged with the owning requester.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   en           gate for new grants (in-flight samples still complete)
//   flush        synchronous discard of all in-flight samples
//   req_valid    per-requester request
//   req_angle    packed S3.4 angles, requester i at [i*W +: W]
//   req_ready    one-hot combinational grant
//   cos_x        registered angle to the cosine unit
//   cos_y        cosine unit result
//   rsp_valid    response strobe, rsp_id owner, rsp_data S3.4 result
//   idle         nothing in flight and no response being presented
module cos_req_arbiter
  import cos_req_arbiter_pkg::*;
#(
  parameter  int NUM_REQ = 4,
  parameter  int LATENCY = COS_LAT,
  localparam int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       en,
  input  logic                       flush,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [NUM_REQ*TOTAL_W-1:0] req_angle,
  output logic [NUM_REQ-1:0]         req_ready,
  output logic [TOTAL_W-1:0]         cos_x,
  input  logic [TOTAL_W-1:0]         cos_y,
  output logic                       rsp_valid,
  output logic [ID_W-1:0]            rsp_id,
  output logic [TOTAL_W-1:0]         rsp_data,
  output logic                       idle
);

  logic [ID_W-1:0]    ptr;
  logic [ID_W-1:0]    ptr_nxt;
  logic               gnt_found;
  logic [ID_W-1:0]    gnt_idx;
  logic [TOTAL_W-1:0] gnt_angle;
  logic               tag_valid;
  logic [ID_W-1:0]    tag_id;
  logic               tag_any;

  // Scan from ptr upward modulo NUM_REQ; first active request wins.
  always_comb begin
    int unsigned cand;
    gnt_found = 1'b0;
    gnt_idx   = '0;
    gnt_angle = '0;
    cand      = 0;
    if (en && !flush) begin
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
        cand = (32'(ptr) + k) % NUM_REQ;
        if (!gnt_found && req_valid[cand]) begin
          gnt_found = 1'b1;
          gnt_idx   = ID_W'(cand);
          gnt_angle = req_angle[cand*TOTAL_W +: TOTAL_W];
        end
      end
    end
    req_ready = NUM_REQ'(gnt_found) << gnt_idx;
    ptr_nxt   = (gnt_idx == ID_W'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr       <= '0;
      cos_x     <= '0;
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_data  <= '0;
    end else begin
      cos_x     <= gnt_found ? gnt_angle : '0;
      if (gnt_found) ptr <= ptr_nxt;
      rsp_valid <= tag_valid && !flush;
      rsp_id    <= tag_id;
      rsp_data  <= cos_y;
    end
  end

  // LATENCY+1 stages: the last one lines up with cos_y.
  cos_tag_pipe #(
    .DEPTH(LATENCY + 1),
    .ID_W (ID_W)
  ) u_tag_pipe (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (flush),
    .in_valid (gnt_found),
    .in_id    (gnt_idx),
    .out_valid(tag_valid),
    .out_id   (tag_id),
    .any_valid(tag_any)
  );

  assign idle = !tag_any && !rsp_valid;

endmodule
